// File: rtl/freq_pkg.sv
// Shared constants for the frequency calculation path: default widths,
// reference clock rate and FSM state encodings.
`timescale 1ns/1ps
package freq_pkg;

    localparam int          CNT_W_DEF       = 28;
    localparam int          OUT_W_DEF       = 32;
    localparam logic [31:0] CLK_FREQ_HZ_DEF = 32'd100_000_000;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_MUL  = 2'd1;
    localparam state_t S_DIV  = 2'd2;
    localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/freq_calc_seq_div.sv
// Generic multi-cycle restoring divider, one quotient bit per clock, MSB first.
// done is high during the final step; quot/rem hold the result from the next cycle.
`timescale 1ns/1ps
module seq_div #(
    parameter int NUM_W = 60,
    parameter int DEN_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quot,
    output logic [DEN_W:0]   rem
);

    localparam int IT_W = $clog2(NUM_W);

    logic            active_r;
    logic [IT_W-1:0] iter_r;
    logic [IT_W-1:0] bit_idx_s;
    logic [DEN_W:0]  rem_sh_s;
    logic [DEN_W:0]  rem_nxt_s;
    logic            ge_s;

    // One restoring step: shift in the next numerator bit and trial-subtract.
    always_comb begin
        bit_idx_s = IT_W'(NUM_W - 1) - iter_r;
        rem_sh_s  = {rem[DEN_W-1:0], num[bit_idx_s]};
        ge_s      = (rem_sh_s >= {1'b0, den});
        if (ge_s) begin
            rem_nxt_s = rem_sh_s - {1'b0, den};
        end else begin
            rem_nxt_s = rem_sh_s;
        end
    end

    assign done = active_r && (iter_r == IT_W'(NUM_W - 1));

    // Iteration control and quotient/remainder registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            iter_r   <= {IT_W{1'b0}};
            quot     <= {NUM_W{1'b0}};
            rem      <= {(DEN_W + 1){1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            iter_r   <= {IT_W{1'b0}};
            quot     <= {NUM_W{1'b0}};
            rem      <= {(DEN_W + 1){1'b0}};
        end else if (active_r) begin
            rem  <= rem_nxt_s;
            quot <= {quot[NUM_W-2:0], ge_s};
            if (done) begin
                active_r <= 1'b0;
            end else begin
                iter_r <= iter_r + IT_W'(1);
            end
        end
    end

endmodule

// File: rtl/freq_calc.sv
// Converts gate-window counts into a frequency in Hz:
// freq = floor(CLK_FREQ_HZ * cnt_squ / cnt_clk), with divide-by-zero and saturation flags.
`timescale 1ns/1ps
module freq_calc
    import freq_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter logic [31:0] CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
    parameter int          OUT_W       = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_clk,
    input  logic [CNT_W-1:0] cnt_squ,
    output logic [OUT_W-1:0] freq_hz,
    output logic             freq_valid,
    output logic             busy,
    output logic             div_err,
    output logic             sat
);

    localparam int NUM_W = CNT_W + 32;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_clk_q_r;
    logic [CNT_W-1:0] cnt_squ_q_r;
    logic             armed_r;
    logic             pending_r;
    logic [CNT_W-1:0] clk_op_r;
    logic [CNT_W-1:0] squ_op_r;
    logic [NUM_W-1:0] num_r;
    logic             chg_s;
    logic             div_start_s;
    logic             div_done_s;
    logic [NUM_W-1:0] div_quot_s;
    logic [CNT_W:0]   div_rem_unused_s;
    logic             ovf_s;

    // armed_r keeps the first post-reset cycle from treating stale inputs as a new measurement.
    assign chg_s       = armed_r && ((cnt_clk != cnt_clk_q_r) || (cnt_squ != cnt_squ_q_r));
    assign div_start_s = (state_r == S_MUL);
    assign ovf_s       = |div_quot_s[NUM_W-1:OUT_W];

    // Input shadows for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_clk_q_r <= {CNT_W{1'b0}};
            cnt_squ_q_r <= {CNT_W{1'b0}};
            armed_r     <= 1'b0;
        end else begin
            cnt_clk_q_r <= cnt_clk;
            cnt_squ_q_r <= cnt_squ;
            armed_r     <= 1'b1;
        end
    end

    // Next-state logic for IDLE -> MUL -> DIV -> DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (chg_s || pending_r) begin
                    state_nxt_s = S_MUL;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MUL:  state_nxt_s = S_DIV;
            S_DIV: begin
                if (div_done_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DIV;
                end
            end
            S_DONE: state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, operand capture, one-deep pending flag and the product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            busy      <= 1'b0;
            pending_r <= 1'b0;
            clk_op_r  <= {CNT_W{1'b0}};
            squ_op_r  <= {CNT_W{1'b0}};
            num_r     <= {NUM_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != S_IDLE);
            if (state_r == S_IDLE) begin
                if (chg_s || pending_r) begin
                    clk_op_r  <= cnt_clk;
                    squ_op_r  <= cnt_squ;
                    pending_r <= 1'b0;
                end
            end else if (chg_s) begin
                pending_r <= 1'b1;
            end
            if (state_r == S_MUL) begin
                num_r <= NUM_W'(CLK_FREQ_HZ) * NUM_W'(squ_op_r);
            end
        end
    end

    seq_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start_s),
        .num   (num_r),
        .den   (clk_op_r),
        .done  (div_done_s),
        .quot  (div_quot_s),
        .rem   (div_rem_unused_s)
    );

    // Result registers: only DONE updates them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_hz    <= {OUT_W{1'b0}};
            freq_valid <= 1'b0;
            div_err    <= 1'b0;
            sat        <= 1'b0;
        end else begin
            freq_valid <= (state_r == S_DONE);
            if (state_r == S_DONE) begin
                if (clk_op_r == {CNT_W{1'b0}}) begin
                    freq_hz <= {OUT_W{1'b0}};
                    div_err <= 1'b1;
                    sat     <= 1'b0;
                end else if (ovf_s) begin
                    freq_hz <= {OUT_W{1'b1}};
                    div_err <= 1'b0;
                    sat     <= 1'b1;
                end else begin
                    freq_hz <= div_quot_s[OUT_W-1:0];
                    div_err <= 1'b0;
                    sat     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: nominal, precision, divide-by-zero, saturation,
// back-to-back pending measurement and reset in the middle of a divide.
`timescale 1ns/1ps
module tb_freq_calc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] cnt_clk = 28'd0;
    logic [27:0] cnt_squ = 28'd0;
    logic [31:0] freq_hz;
    logic        freq_valid;
    logic        busy;
    logic        div_err;
    logic        sat;

    int errors = 0;
    int checks = 0;
    int cyc;
    int pulses;

    freq_calc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_clk    (cnt_clk),
        .cnt_squ    (cnt_squ),
        .freq_hz    (freq_hz),
        .freq_valid (freq_valid),
        .busy       (busy),
        .div_err    (div_err),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keeps stepping until freq_valid; cyc = -1 when the bound expires.
    task automatic run_until_valid(inout int n);
        while (!freq_valid && n < 300) begin
            step();
            n++;
        end
        if (!freq_valid) n = -1;
    endtask

    // Counts edges after the edge that samples the input change.
    task automatic wait_valid(output int n);
        step();
        n = 0;
        run_until_valid(n);
    endtask

    task automatic apply(input logic [27:0] c, input logic [27:0] s);
        cnt_clk = c;
        cnt_squ = s;
    endtask

    initial begin
        step();
        step();
        check("rst_freq", 64'(freq_hz), 64'd0);
        check("rst_valid", 64'(freq_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(div_err), 64'd0);
        check("rst_sat", 64'(sat), 64'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // 1. nominal
        apply(28'd100_000_000, 28'd1000);
        wait_valid(cyc);
        check("nom_latency", 64'(cyc), 64'd62);
        check("nom_freq", 64'(freq_hz), 64'd1000);
        check("nom_err", 64'(div_err), 64'd0);
        check("nom_sat", 64'(sat), 64'd0);
        step();
        check("nom_pulse_end", 64'(freq_valid), 64'd0);
        check("nom_hold", 64'(freq_hz), 64'd1000);
        repeat (2) step();

        // 2. precision / truncation
        apply(28'd99_999_990, 28'd12_345_678);
        wait_valid(cyc);
        check("prec_freq", 64'(freq_hz), 64'd12_345_679);
        repeat (2) step();

        // 3. divide by zero
        apply(28'd0, 28'd5);
        wait_valid(cyc);
        check("dz_latency", 64'(cyc), 64'd62);
        check("dz_freq", 64'(freq_hz), 64'd0);
        check("dz_err", 64'(div_err), 64'd1);
        check("dz_sat", 64'(sat), 64'd0);
        repeat (2) step();

        // 4. saturation
        apply(28'd1, 28'd100);
        wait_valid(cyc);
        check("sat_freq", 64'(freq_hz), 64'hFFFF_FFFF);
        check("sat_flag", 64'(sat), 64'd1);
        check("sat_err", 64'(div_err), 64'd0);
        repeat (2) step();

        // 5. back-to-back: second measurement arrives mid-divide
        apply(28'd100_000_000, 28'd500);
        step();
        cyc = 0;
        repeat (11) begin
            step();
            cyc++;
        end
        check("b2b_busy_mid", 64'(busy), 64'd1);
        cnt_squ = 28'd2000;
        run_until_valid(cyc);
        check("b2b_first_latency", 64'(cyc), 64'd62);
        check("b2b_first_freq", 64'(freq_hz), 64'd500);
        step();
        cyc = 1;
        run_until_valid(cyc);
        check("b2b_second_latency", 64'(cyc), 64'd63);
        check("b2b_second_freq", 64'(freq_hz), 64'd2000);
        repeat (2) step();

        // 6. reset at divide iteration 30
        apply(28'd50_000_000, 28'd7);
        step();
        repeat (32) step();
        check("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_freq", 64'(freq_hz), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(freq_valid), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (freq_valid) pulses++;
        end
        check("post_rst_pulses", 64'(pulses), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_freq", 64'(freq_hz), 64'd0);

        // Fresh measurement after reset still works.
        apply(28'd25_000_000, 28'd3);
        wait_valid(cyc);
        check("after_rst_latency", 64'(cyc), 64'd62);
        check("after_rst_freq", 64'(freq_hz), 64'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
